ctrl_mem_read_out: RTL and testbench

Streams a block of result words out of the local memory to the downstream consumer. It is the transmit-side counterpart of the input loader: it issues memory reads and presents the data on an AXI-style valid/ready master port. It sits between the result memory and the module output. It sustains one word per cycle despite the memory's one-cycle read latency, and it never drops or duplicates a word under back-pressure.

---
 rtl/ctrl_mem_pkg.sv | 12 +
 rtl/ctrl_mem_read_out_if.sv | 40 ++++
 rtl/ctrl_mem_read_out_fifo.sv | 55 +++++
 rtl/ctrl_mem_read_out.sv | 172 +++++++++++++++++
 tb/tb_ctrl_mem_read_out.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_mem_pkg.sv
// Shared types and defaults for the result-memory read-out block.
package ctrl_mem_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } rd_state_t;

endpackage

// File: rtl/ctrl_mem_read_out_if.sv
// Memory read port plus valid/ready output stream of ctrl_mem_read_out.
// m_last exists only when CTRL_MEM_RD_LAST_EN is defined.
interface ctrl_mem_read_out_if
  import ctrl_mem_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 3,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF
);

  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic                      mem_rd_en;
  logic [DATA_WIDTH-1:0]     mem_rd_data;
  logic                      m_valid;
  logic                      m_ready;
  logic [DATA_WIDTH-1:0]     m_data;
`ifdef CTRL_MEM_RD_LAST_EN
  logic                      m_last;

  modport master (
    output mem_addr, mem_rd_en, m_valid, m_data, m_last,
    input  mem_rd_data, m_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, m_valid, m_data, m_last,
    output mem_rd_data, m_ready
  );
`else
  modport master (
    output mem_addr, mem_rd_en, m_valid, m_data,
    input  mem_rd_data, m_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, m_valid, m_data,
    output mem_rd_data, m_ready
  );
`endif

endinterface

// File: rtl/ctrl_mem_read_out_fifo.sv
// out_fifo2: two-entry synchronous FIFO; push while full is accepted only
// together with a pop.
module out_fifo2 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry_r [2];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [1:0]       count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == 2'd0);
  assign full      = (count_r == 2'd2);
  assign count     = count_r;
  assign dout      = entry_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Entry storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_r[0] <= {WIDTH{1'b0}};
      entry_r[1] <= {WIDTH{1'b0}};
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
    end else begin
      if (do_push_s) begin
        entry_r[wr_ptr_r] <= din;
        wr_ptr_r          <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ctrl_mem_read_out.sv
// Streams `length` words from result memory address 0 upward onto a valid/ready
// port. Optional feature macro: CTRL_MEM_RD_LAST_EN (adds m_last).
module ctrl_mem_read_out
  import ctrl_mem_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 3,
  parameter int MEM_SIZE       = 8,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [MEM_ADDR_WIDTH:0] length,
  ctrl_mem_read_out_if.master     bus,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = MEM_ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MEM_SIZE_C = CW'(MEM_SIZE);
  localparam logic [CW-1:0] ONE_C      = CW'(1);
  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR_C = MEM_ADDR_WIDTH'(MEM_SIZE - 1);
`ifdef CTRL_MEM_RD_LAST_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif

  rd_state_t                 state_r;
  rd_state_t                 state_s;
  logic [CW-1:0]             len_r;
  logic [CW-1:0]             read_cnt_r;
  logic [CW-1:0]             sent_cnt_r;
  logic [MEM_ADDR_WIDTH-1:0] addr_r;
  logic                      inflight_r;
  logic                      done_r;
  logic                      done_s;

  logic [CW-1:0]             clamped_len_s;
  logic [CW-1:0]             len_m1_s;
  logic                      start_ok_s;
  logic                      pop_s;
  logic [2:0]                occ_s;
  logic                      rd_en_s;
  logic                      last_rd_s;
  logic                      last_pop_s;

  logic [FW-1:0]             fifo_din_s;
  logic [FW-1:0]             fifo_dout_s;
  logic                      fifo_empty_s;
  logic                      fifo_full_s;
  logic [1:0]                fifo_count_s;

  assign clamped_len_s = (length > MEM_SIZE_C) ? MEM_SIZE_C : length;
  assign len_m1_s      = len_r - ONE_C;
  // A start landing on the done cycle is dropped so done/start never overlap.
  assign start_ok_s    = start & (state_r == IDLE) & ~done_r;
  assign pop_s         = ~fifo_empty_s & bus.m_ready;
  // Words that will be buffered or in flight after this cycle, before any new read.
  assign occ_s         = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign rd_en_s       = (state_r == STREAM) & (read_cnt_r < len_r) &
                         ~(fifo_full_s & ~pop_s) & (occ_s < 3'd2);
  assign last_rd_s     = rd_en_s & (read_cnt_r == len_m1_s);
  assign last_pop_s    = pop_s & (sent_cnt_r == len_m1_s);

  // Next-state and done-pulse decode
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_ok_s && (clamped_len_s != {CW{1'b0}})) begin
          state_s = STREAM;
        end else if (start_ok_s) begin
          done_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if (last_rd_s) begin
          state_s = DRAIN;
        end else begin
          state_s = STREAM;
        end
      end
      DRAIN: begin
        if (last_pop_s) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, word counters and read address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      len_r      <= {CW{1'b0}};
      read_cnt_r <= {CW{1'b0}};
      sent_cnt_r <= {CW{1'b0}};
      addr_r     <= {MEM_ADDR_WIDTH{1'b0}};
      inflight_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      done_r     <= done_s;
      inflight_r <= rd_en_s;
      if (start_ok_s) begin
        len_r      <= clamped_len_s;
        read_cnt_r <= {CW{1'b0}};
        sent_cnt_r <= {CW{1'b0}};
        addr_r     <= {MEM_ADDR_WIDTH{1'b0}};
      end else begin
        if (rd_en_s) begin
          read_cnt_r <= read_cnt_r + ONE_C;
          addr_r     <= (addr_r == LAST_ADDR_C) ? {MEM_ADDR_WIDTH{1'b0}}
                                                : addr_r + {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
        if (pop_s) begin
          sent_cnt_r <= sent_cnt_r + ONE_C;
        end
      end
    end
  end

`ifdef CTRL_MEM_RD_LAST_EN
  logic inflight_last_r;

  // Tags the word in flight from memory as the final one of the transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_last_r <= 1'b0;
    end else begin
      inflight_last_r <= last_rd_s;
    end
  end

  assign fifo_din_s = {inflight_last_r, bus.mem_rd_data};
  assign bus.m_last = ~fifo_empty_s & fifo_dout_s[DATA_WIDTH];
`else
  assign fifo_din_s = bus.mem_rd_data;
`endif

  out_fifo2 #(
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_r),
    .pop   (pop_s),
    .din   (fifo_din_s),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .count (fifo_count_s)
  );

  assign bus.mem_addr  = addr_r;
  assign bus.mem_rd_en = rd_en_s;
  assign bus.m_valid   = ~fifo_empty_s;
  assign bus.m_data    = fifo_dout_s[DATA_WIDTH-1:0];
  assign busy          = (state_r != IDLE);
  assign done          = done_r;

endmodule

// File: tb/tb_ctrl_mem_read_out.sv
// Randomized self-checking bench for ctrl_mem_read_out against a word-sequence
// reference model (words mem[0..min(len,8)-1] in order, timing from cycle rules).
module tb_ctrl_mem_read_out;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] length;
  logic       busy;
  logic       done;
  int         checks;
  int         errors;
  logic [15:0] mem [8];

  ctrl_mem_read_out_if #(.MEM_ADDR_WIDTH(3), .DATA_WIDTH(16)) bus ();

  ctrl_mem_read_out #(
    .MEM_ADDR_WIDTH (3),
    .MEM_SIZE       (8),
    .DATA_WIDTH     (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .length (length),
    .bus    (bus),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with one-cycle read latency
  always_ff @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
  end

  function automatic logic ready_of(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2 == 0);
      2:       return 1'($urandom_range(0, 1));
      3:       return (cyc > 10);
      default: return 1'b1;
    endcase
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
  endtask

  // mode: 0 ready high, 1 toggling 1/0, 2 random, 3 low for cycles 1..10
  task automatic run_xfer(input int len, input int mode);
    int exp_n, reads, pops, cyc;
    bit done_seen;
    logic prev_v, prev_r;
    logic [15:0] prev_d;
    exp_n = (len > 8) ? 8 : len;
    reads = 0; pops = 0; done_seen = 1'b0; cyc = 0;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = 16'd0;
    @(posedge clk); #1;
    start = 1'b1; length = 4'(len); bus.m_ready = ready_of(mode, 0);
    while (cyc < 120 && !done_seen) begin
      cyc++;
      @(posedge clk); #1;
      start = 1'b0; bus.m_ready = ready_of(mode, cyc);
      @(negedge clk);
      if (prev_v && !prev_r) begin
        checks++;
        if (!bus.m_valid || bus.m_data !== prev_d) begin
          errors++;
          $display("FAIL hold len=%0d cyc=%0d valid=%b data=%h required valid=1 data=%h",
                   len, cyc, bus.m_valid, bus.m_data, prev_d);
        end
      end
`ifdef CTRL_MEM_RD_LAST_EN
      if (bus.m_valid) begin
        checks++;
        if (bus.m_last !== (pops == exp_n - 1)) begin
          errors++;
          $display("FAIL m_last len=%0d word=%0d got=%b required=%b",
                   len, pops, bus.m_last, (pops == exp_n - 1));
        end
      end
`endif
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        if (pops >= exp_n) begin
          errors++;
          $display("FAIL extra_word len=%0d cyc=%0d data=%h required no word", len, cyc, bus.m_data);
        end else if (bus.m_data !== mem[pops]) begin
          errors++;
          $display("FAIL word len=%0d idx=%0d got=%h required=%h", len, pops, bus.m_data, mem[pops]);
        end
        pops++;
      end
      if (bus.mem_rd_en) begin
        checks++;
        if (bus.mem_addr !== 3'(reads) || reads >= exp_n) begin
          errors++;
          $display("FAIL read len=%0d read#%0d addr=%0d required addr=%0d within %0d reads",
                   len, reads, bus.mem_addr, reads, exp_n);
        end
        reads++;
      end
      checks++;
      if (reads - pops > 2) begin
        errors++;
        $display("FAIL buffer len=%0d cyc=%0d outstanding=%0d required<=2", len, cyc, reads - pops);
      end
      if (mode == 0) begin
        checks++;
        if (bus.mem_rd_en !== (cyc >= 1 && cyc <= exp_n) ||
            bus.m_valid !== (cyc >= 3 && cyc <= exp_n + 2)) begin
          errors++;
          $display("FAIL timing len=%0d cyc=%0d rd_en=%b valid=%b required rd_en=%b valid=%b",
                   len, cyc, bus.mem_rd_en, bus.m_valid, (cyc >= 1 && cyc <= exp_n),
                   (cyc >= 3 && cyc <= exp_n + 2));
        end
      end
      if (mode == 3 && cyc == 10) begin
        checks++;
        if (reads != ((exp_n < 2) ? exp_n : 2) || bus.m_valid !== (exp_n > 0)) begin
          errors++;
          $display("FAIL stall len=%0d reads=%0d valid=%b required reads=%0d valid=%b",
                   len, reads, bus.m_valid, (exp_n < 2) ? exp_n : 2, (exp_n > 0));
        end
      end
      if (done) begin
        done_seen = 1'b1;
        checks++;
        if (pops != exp_n || reads != exp_n || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_count len=%0d pops=%0d reads=%0d busy=%b required %0d/%0d busy=0",
                   len, pops, reads, busy, exp_n, exp_n);
        end
        if (mode == 0) begin
          checks++;
          if (cyc != ((exp_n == 0) ? 1 : exp_n + 3)) begin
            errors++;
            $display("FAIL done_cycle len=%0d got=%0d required=%0d",
                     len, cyc, (exp_n == 0) ? 1 : exp_n + 3);
          end
        end
      end else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy len=%0d cyc=%0d got=%b required=1", len, cyc, busy);
        end
      end
      prev_v = bus.m_valid; prev_r = bus.m_ready; prev_d = bus.m_data;
    end
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL timeout len=%0d got no done required done within 120 cycles", len);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done len=%0d done=%b busy=%b required 0 0", len, done, busy);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (bus.mem_rd_en !== 1'b0 || bus.mem_addr !== 3'd0 || bus.m_valid !== 1'b0 ||
        bus.m_data !== 16'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s rd_en=%b addr=%0d valid=%b data=%h busy=%b done=%b required all 0",
               tag, bus.mem_rd_en, bus.mem_addr, bus.m_valid, bus.m_data, busy, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; length = 4'd0; bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset_hold");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_release");
  endtask

  task automatic test_basic();
    run_xfer(4, 0);
    run_xfer(1, 0);
  endtask

  task automatic test_backpressure();
    run_xfer(8, 1);
    run_xfer(3, 3);
  endtask

  task automatic test_length_bounds();
    run_xfer(0, 0);
    run_xfer(12, 0);
    run_xfer(15, 2);
  endtask

  task automatic test_start_rules();
    @(posedge clk); #1;
    start = 1'b1; length = 4'd2; bus.m_ready = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      start  = (cyc == 2 || cyc == 5 || cyc == 6);
      length = (cyc == 6) ? 4'd1 : 4'd5;
      @(negedge clk);
      if (cyc == 3 || cyc == 6) begin
        checks++;
        if (bus.mem_rd_en !== 1'b0 || (cyc == 6 && busy !== 1'b0)) begin
          errors++;
          $display("FAIL start_ignored cyc=%0d rd_en=%b busy=%b required 0", cyc, bus.mem_rd_en, busy);
        end
      end
      if (cyc == 5 || cyc == 10) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL start_done cyc=%0d done=%b busy=%b required 1 0", cyc, done, busy);
        end
      end
      if (cyc == 7) begin
        checks++;
        if (busy !== 1'b1 || bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 3'd0) begin
          errors++;
          $display("FAIL start_accept busy=%b rd_en=%b addr=%0d required 1 1 0",
                   busy, bus.mem_rd_en, bus.mem_addr);
        end
      end
      if (cyc == 9) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== mem[0]) begin
          errors++;
          $display("FAIL start_word valid=%b data=%h required 1 %h", bus.m_valid, bus.m_data, mem[0]);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    int pops;
    pops = 0;
    @(posedge clk); #1;
    start = 1'b1; length = 4'd6; bus.m_ready = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) pops++;
    end
    checks++;
    if (pops != 2) begin
      errors++;
      $display("FAIL mid_progress got=%0d words required=2", pops);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || bus.m_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_no_done done=%b valid=%b required 0 0", done, bus.m_valid);
      end
    end
    run_xfer(2, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      fill_mem();
      run_xfer(int'($urandom_range(0, 15)), 2);
    end
  endtask

`ifdef CTRL_MEM_RD_LAST_EN
  task automatic test_last();
    run_xfer(5, 1);
    run_xfer(5, 3);
    run_xfer(5, 2);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    bus.mem_rd_data = 16'd0;
    fill_mem();
    test_reset();
    test_basic();
    test_backpressure();
    test_length_bounds();
    test_start_rules();
    test_reset_mid();
    test_random();
`ifdef CTRL_MEM_RD_LAST_EN
    test_last();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
